cordic_vec_iter: RTL and testbench

CORDIC_VEC_ITER -- requirements
Module: cordic_vec_iter

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_atan_rom.sv | 21 ++
 rtl/cordic_vec_iter.sv | 165 ++++++++++++++++
 tb/tb_cordic_vec_iter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC vectoring block: FSM states,
// gain-compensation constant, angle constants and the arctangent table.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // CORDIC gain compensation 1/1.64676 = 0.60725 in Q0.16.
  localparam logic [15:0] K_Q16 = 16'd39797;

  // Angle constants in Q3.12 radians.
  localparam logic signed [15:0] PI_Q12      = 16'sd12868;
  localparam logic signed [15:0] HALF_PI_Q12 = 16'sd6434;

  // atan(2^-i) in Q3.12 radians.
  localparam int ATAN_N = 10;
  localparam logic signed [15:0] ATAN_Q12 [ATAN_N] = '{
    16'sd3217, 16'sd1899, 16'sd1003, 16'sd509, 16'sd256,
    16'sd128,  16'sd64,   16'sd32,   16'sd16,  16'sd8
  };

  // Rescale a Q3.12 angle to Q3.(width-4).
  function automatic logic signed [31:0] scale_q12(input logic signed [15:0] v,
                                                   input int width);
    logic signed [31:0] w;
    w = 32'(v);
    if (width >= 16) return w <<< (width - 16);
    return w >>> (16 - width);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent lookup: iteration index -> atan(2^-idx) in Q3.(WIDTH-4) radians.
// Indices beyond the table return 0.
module cordic_atan_rom #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]        idx,
  output logic signed [WIDTH-1:0] atan
);
  import cordic_pkg::*;

  // Table lookup with out-of-range indices mapped to zero.
  always_comb begin
    // NOTE: the output gets a default before any conditional assignment, so no latch is inferred.
    atan = '0;
    for (int k = 0; k < ATAN_N; k++) begin
      if (32'(idx) == k) atan = WIDTH'(scale_q12(ATAN_Q12[k], WIDTH));
    end
  end

endmodule

// File: rtl/cordic_vec_iter.sv
// Iterative CORDIC vectoring unit: converts (x_in, y_in) to magnitude and
// angle, one micro-rotation per clock.
// Build option: define CORDIC_GAIN_COMP_EN to add the COMP state that scales
// the magnitude by 1/gain (latency ITER+2); otherwise mag is the raw,
// saturated CORDIC x (gain ~1.6468, latency ITER+1).
module cordic_vec_iter #(
  parameter int WIDTH = 16,
  parameter int ITER  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        mag,
  output logic signed [WIDTH-1:0] ang
);
  import cordic_pkg::*;

  localparam int XW    = WIDTH + 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic signed [WIDTH-1:0] PI_Z = WIDTH'(scale_q12(PI_Q12, WIDTH));

  state_t state, state_nxt;

  logic signed [XW-1:0]    x, y;
  logic signed [WIDTH-1:0] z;
  logic [CNT_W-1:0]        cnt;
  logic                    zero_op;
  logic                    last;

  logic signed [XW-1:0]    x_ext, y_ext, x_sh, y_sh, x_rot, y_rot;
  logic signed [WIDTH-1:0] z_rot, atan_i;
  logic                    d;

  // Clamp a guarded x to the unsigned magnitude range.
  function automatic logic [WIDTH-1:0] sat_mag(input logic signed [XW-1:0] v);
    if (v[XW-1]) return '0;
    if (v[XW-2]) return '1;
    return v[WIDTH-1:0];
  endfunction

  cordic_atan_rom #(
    .WIDTH(WIDTH),
    .IDX_W(CNT_W)
  ) u_atan (
    .idx (cnt),
    .atan(atan_i)
  );

  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};
  assign last  = (cnt == CNT_W'(ITER - 1));

  // One micro-rotation from the current (pre-update) x, y, z.
  always_comb begin
    x_sh  = x >>> cnt;
    y_sh  = y >>> cnt;
    d     = y[XW-1];
    x_rot = d ? (x - y_sh) : (x + y_sh);
    y_rot = d ? (y + x_sh) : (y - x_sh);
    z_rot = zero_op ? z : (d ? (z - atan_i) : (z + atan_i));
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic [XW+15:0]       prod;
  logic signed [XW-1:0] x_scaled;

  // Gain compensation: x * K, truncated (x is never negative after vectoring).
  always_comb begin
    prod     = {16'd0, (x[XW-1] ? {XW{1'b0}} : x)} * {{XW{1'b0}}, K_Q16};
    x_scaled = prod[XW+15:16];
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_ROT;
      end
      ST_ROT: begin
`ifdef CORDIC_GAIN_COMP_EN
        if (last) state_nxt = ST_COMP;
`else
        if (last) state_nxt = ST_DONE;
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_COMP: state_nxt = ST_DONE;
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: quadrant pre-rotation, iterations, result capture.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, since their idle values are visible on mag/ang.
    if (!rst) begin
      x       <= '0;
      y       <= '0;
      z       <= '0;
      cnt     <= '0;
      zero_op <= 1'b0;
      mag     <= '0;
      ang     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cnt     <= '0;
            zero_op <= (x_in == '0) && (y_in == '0);
            if (x_in[WIDTH-1]) begin
              // Guard bits keep -(-2^(WIDTH-1)) representable.
              x <= -x_ext;
              y <= -y_ext;
              z <= y_in[WIDTH-1] ? -PI_Z : PI_Z;
            end else begin
              x <= x_ext;
              y <= y_ext;
              z <= '0;
            end
          end
        end
        ST_ROT: begin
          x <= x_rot;
          y <= y_rot;
          z <= z_rot;
          if (last) begin
            cnt <= '0;
            ang <= z_rot;
`ifndef CORDIC_GAIN_COMP_EN
            mag <= sat_mag(x_rot);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: mag <= sat_mag(x_scaled);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Scoreboard bench for cordic_vec_iter: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares each delivered result.
// Latency is counted from the accepting edge to the first edge at which the
// consumer can sample out_valid high.
module tb_cordic_vec_iter;

`ifdef CORDIC_GAIN_COMP_EN
  localparam bit COMP = 1'b1;
  localparam int LAT  = 12;
`else
  localparam bit COMP = 1'b0;
  localparam int LAT  = 11;
`endif
  localparam int MAG_TOL = 8;
  localparam int ANG_TOL = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [15:0]        mag;
  logic signed [15:0] ang;

  typedef struct {
    int mag;
    int ang;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   fresh    = 1'b1;

  cordic_vec_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag      (mag),
    .ang      (ang)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req, input int tol);
    int diff;
    checks++;
    diff = act - req;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
    end
  endtask

  // Monitor: records acceptances, checks latency, pops and compares results.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst) begin
      exp_q.delete();
      acc_q.delete();
      fresh = 1'b1;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && fresh) begin
        fresh = 1'b0;
        if (acc_q.size() == 0) begin
          check("unexpected_out", int'(out_valid), 0, 0);
        end else begin
          a = acc_q.pop_front();
          check("latency", (cyc + 1) - a, LAT, 0);
        end
      end
      if (out_valid && out_ready) begin
        fresh = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(out_valid), 0, 0);
        end else begin
          e = exp_q.pop_front();
          check("mag", int'(mag), e.mag, MAG_TOL);
          check("ang", int'(ang), e.ang, ANG_TOL);
        end
      end
    end
  end

  task automatic send(input int xi, input int yi, input int em, input int ea);
    exp_t e;
    bit   done;
    e.mag = em;
    e.ang = ea;
    exp_q.push_back(e);
    x_in     = 16'(xi);
    y_in     = 16'(yi);
    in_valid = 1'b1;
    done     = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", int'(in_ready), 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0, 0);
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: x, y, mag (compensated), mag (raw gain), angle Q3.12.
  int vx[7]   = '{ 8192, 5793,     0, -8192, 0, -32768, -32768};
  int vy[7]   = '{    0, 5793, -8192,     0, 0,      0, -32768};
  int vmc[7]  = '{ 8192, 8192,  8192,  8192, 0,  32768,  46341};
  int vmr[7]  = '{13491,13491, 13491, 13491, 0,  53961,  65535};
  int va[7]   = '{    0, 3217, -6434, 12868, 0,  12868,  -9651};

  function automatic int pick_mag(input int mc, input int mr);
    return COMP ? mc : mr;
  endfunction

  initial begin
    int held_mag;
    int held_ang;
    bit seen;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_mag", int'(mag), 0, 0);
    check("rst_ang", int'(ang), 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time.
    for (int i = 0; i < 7; i++) begin
      send(vx[i], vy[i], pick_mag(vmc[i], vmr[i]), va[i]);
      drain();
    end

    // Backpressure in DONE, then a back-to-back operand.
    out_ready = 1'b0;
    send(8192, 0, pick_mag(8192, 13491), 0);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("hold_wait", int'(seen), 1, 0);
    held_mag = int'(mag);
    held_ang = int'(ang);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1, 0);
      check("hold_in_ready", int'(in_ready), 0, 0);
      check("hold_mag", int'(mag), held_mag, 0);
      check("hold_ang", int'(ang), held_ang, 0);
    end
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.mag = pick_mag(8192, 13491);
      e.ang = 6434;
      exp_q.push_back(e);
    end
    x_in      = 16'sd0;
    y_in      = 16'sd8192;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready", int'(in_ready), 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_accepted", int'(in_ready), 0, 0);
    drain();

    // Reset during the fourth rotation cycle abandons the operation.
    send(8192, 0, pick_mag(8192, 13491), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", int'(out_valid), 0, 0);
    check("abort_in_ready", int'(in_ready), 1, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    send(5793, 5793, pick_mag(8192, 13491), 3217);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
